// File: rtl/core_dout_tx_pkg.sv
// Shared definitions for the core result link (transmitter and output processor).
package core_dout_tx_pkg;

    localparam int INDEX_W       = 16;
    localparam int PKT_LEN_SHORT = 2;
    localparam int PKT_LEN_LONG  = 6;

    // Nibble field positions
    localparam int NIB_START_BIT = 0;   // in n0
    localparam int NIB_BC_BIT    = 0;   // in n1
    localparam int NIB_EQ_BIT    = 1;   // in n1

    localparam logic [3:0] NIB_START = 4'(1 << NIB_START_BIT);
    localparam logic [3:0] NIB_IDLE  = 4'h0;

    // Last value of the index-nibble counter in a long packet
    localparam logic [1:0] DATA_LAST = 2'(PKT_LEN_LONG - PKT_LEN_SHORT - 1);

    // FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_FLAGS = 2'd2;
    localparam logic [1:0] ST_DATA  = 2'd3;

    typedef struct packed {
        logic               equal;
        logic               batch_complete;
        logic [INDEX_W-1:0] index;
    } result_t;

    localparam int RESULT_W = $bits(result_t);

    function automatic logic [3:0] flags_nibble(input result_t r);
        logic [3:0] n;
        n             = 4'h0;
        n[NIB_EQ_BIT] = r.equal;
        n[NIB_BC_BIT] = r.batch_complete;
        return n;
    endfunction

    // Index nibbles go out most significant first: sel 0 -> index[15:12]
    function automatic logic [3:0] index_nibble(input logic [INDEX_W-1:0] idx,
                                                input logic [1:0]         sel);
        return idx[4*(3-int'(sel)) +: 4];
    endfunction

endpackage

// File: rtl/core_dout_tx_if.sv
// Result-write side and nibble-link side of the core transmitter.
interface core_dout_tx_if;
    import core_dout_tx_pkg::*;

    logic               wr_en;
    logic               equal;
    logic               batch_complete;
    logic [INDEX_W-1:0] index;
    logic               full;
    logic               idle;
    logic [3:0]         core_dout;
    logic               core_dout_ready;
    logic               err_cmd;
    logic               err_overflow;

    modport master (
        output wr_en, equal, batch_complete, index, core_dout_ready,
        input  full, idle, core_dout, err_cmd, err_overflow
    );

    modport slave (
        input  wr_en, equal, batch_complete, index, core_dout_ready,
        output full, idle, core_dout, err_cmd, err_overflow
    );

endinterface

// File: rtl/core_dout_tx_buf.sv
// First-word-fall-through FIFO holding pending comparator results.
module result_buf #(
    parameter int ADDR_BITS = 1,
    parameter int DATA_W    = 18
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [ADDR_BITS:0] r_wr_ptr;
    logic [ADDR_BITS:0] r_rd_ptr;
    logic               w_wr;
    logic               w_rd;

    // A pop frees a slot in the same cycle, so a write while full is taken if paired with a pop
    assign w_wr  = wr_en && (!full || rd_en);
    assign w_rd  = rd_en && !empty;
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = ({~r_wr_ptr[ADDR_BITS], r_wr_ptr[ADDR_BITS-1:0]} == r_rd_ptr);
    assign dout  = r_mem[r_rd_ptr[ADDR_BITS-1:0]];

    // Storage array, data only
    always_ff @(posedge CLK) begin
        if (w_wr) r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= din;
    end

    // Read/write pointers with wrap bit
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/core_dout_tx.sv
// Core-side result transmitter: buffers results and serializes each one as a nibble packet.
module core_dout_tx
    import core_dout_tx_pkg::*;
#(
    parameter int BUF_ADDR_BITS = 1
) (
    input  logic           CLK,
    input  logic           RST,
    core_dout_tx_if.slave  bus
);
    result_t    w_wr_data;
    result_t    w_head;
    logic       w_valid_cmd;
    logic       w_push;
    logic       w_empty;
    logic       w_full;
    logic       w_launch;

    logic [1:0] r_state;
    logic [1:0] r_cnt;
    logic [3:0] r_dout;
    result_t    r_hold;
    logic       r_armed;
    logic       r_err_cmd;
    logic       r_err_overflow;

    assign w_valid_cmd = bus.equal || bus.batch_complete;
    assign w_push      = bus.wr_en && w_valid_cmd;
    assign w_wr_data   = '{equal: bus.equal, batch_complete: bus.batch_complete, index: bus.index};
    // Only start on a ready seen low since the last packet began
    assign w_launch    = (r_state == ST_IDLE) && !w_empty && bus.core_dout_ready && r_armed;

    result_buf #(
        .ADDR_BITS (BUF_ADDR_BITS),
        .DATA_W    (RESULT_W)
    ) u_buf (
        .CLK   (CLK),
        .RST   (RST),
        .wr_en (w_push),
        .din   (w_wr_data),
        .rd_en (w_launch),
        .dout  (w_head),
        .empty (w_empty),
        .full  (w_full)
    );

    // Packet sequencer: one nibble registered per cycle, 4'h0 between packets
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_dout  <= NIB_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_dout  <= NIB_START;
                        r_state <= ST_START;
                    end else begin
                        r_dout  <= NIB_IDLE;
                    end
                end
                ST_START: begin
                    r_dout  <= flags_nibble(r_hold);
                    r_state <= ST_FLAGS;
                end
                ST_FLAGS: begin
                    if (r_hold.equal) begin
                        r_dout  <= index_nibble(r_hold.index, 2'd0);
                        r_cnt   <= 2'd0;
                        r_state <= ST_DATA;
                    end else begin
                        r_dout  <= NIB_IDLE;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    // r_cnt names the index nibble currently on the link
                    if (r_cnt == DATA_LAST) begin
                        r_dout  <= NIB_IDLE;
                        r_state <= ST_IDLE;
                    end else begin
                        r_dout  <= index_nibble(r_hold.index, r_cnt + 2'd1);
                        r_cnt   <= r_cnt + 2'd1;
                    end
                end
                default: begin
                    r_dout  <= NIB_IDLE;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Holding register for the packet in flight
    always_ff @(posedge CLK) begin
        if (w_launch) r_hold <= w_head;
    end

    // Armed: cleared on start nibble, re-armed by any sampled ready=0
    always_ff @(posedge CLK) begin
        if (RST)                       r_armed <= 1'b1;
        else if (w_launch)             r_armed <= 1'b0;
        else if (!bus.core_dout_ready) r_armed <= 1'b1;
    end

    // Sticky error flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err_cmd      <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            if (bus.wr_en && !w_valid_cmd)         r_err_cmd      <= 1'b1;
            if (w_push && w_full && !w_launch)     r_err_overflow <= 1'b1;
        end
    end

    assign bus.core_dout    = r_dout;
    assign bus.full         = w_full;
    assign bus.idle         = w_empty && (r_state == ST_IDLE);
    assign bus.err_cmd      = r_err_cmd;
    assign bus.err_overflow = r_err_overflow;

endmodule

// File: tb/tb_core_dout_tx.sv
// Directed bench for core_dout_tx: packet timing, ready re-arm, overflow, bad commands, reset abort.
module tb_core_dout_tx;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_pass;

    core_dout_tx_if bus_if ();

    core_dout_tx #(
        .BUF_ADDR_BITS (1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic write(input logic eq, input logic bc, input logic [15:0] idx);
        bus_if.wr_en          = 1'b1;
        bus_if.equal          = eq;
        bus_if.batch_complete = bc;
        bus_if.index          = idx;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_a [7];
        logic [3:0] exp_e [7];
        exp_a = '{4'h1, 4'h2, 4'hA, 4'h5, 4'hC, 4'h3, 4'h0};
        exp_e = '{4'h1, 4'h3, 4'h0, 4'hF, 4'h9, 4'h6, 4'h0};
        n_checks = 0;
        n_pass   = 0;

        bus_if.wr_en           = 1'b0;
        bus_if.equal           = 1'b0;
        bus_if.batch_complete  = 1'b0;
        bus_if.index           = 16'h0;
        bus_if.core_dout_ready = 1'b1;
        RST                    = 1'b1;

        // Reset held three cycles
        tick(); tick(); tick();
        RST = 1'b0;
        chk("rst_dout", 32'(bus_if.core_dout), 32'h0);
        chk("rst_full", 32'(bus_if.full), 32'h0);
        chk("rst_idle", 32'(bus_if.idle), 32'h1);
        chk("rst_err_cmd", 32'(bus_if.err_cmd), 32'h0);
        chk("rst_err_ovf", 32'(bus_if.err_overflow), 32'h0);

        // Long packet: equal=1, index A5C3
        write(1'b1, 1'b0, 16'hA5C3);
        tick();
        bus_if.wr_en = 1'b0;
        chk("A_t1_dout", 32'(bus_if.core_dout), 32'h0);
        chk("A_t1_idle", 32'(bus_if.idle), 32'h0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("A_nib%0d", i), 32'(bus_if.core_dout), 32'(exp_a[i]));
        end
        chk("A_end_idle", 32'(bus_if.idle), 32'h1);

        // Re-arm with one ready=0 cycle
        bus_if.core_dout_ready = 1'b0;
        tick();
        bus_if.core_dout_ready = 1'b1;

        // Two short packets back-to-back, ready low t+3..t+9
        write(1'b0, 1'b1, 16'h0);
        tick();
        tick();
        bus_if.wr_en = 1'b0;
        chk("B_t2_n0", 32'(bus_if.core_dout), 32'h1);
        tick();
        chk("B_t3_n1", 32'(bus_if.core_dout), 32'h1);
        bus_if.core_dout_ready = 1'b0;
        for (int k = 4; k <= 10; k++) begin
            tick();
            chk($sformatf("B_t%0d_gap", k), 32'(bus_if.core_dout), 32'h0);
        end
        bus_if.core_dout_ready = 1'b1;
        tick();
        chk("B_t11_n0", 32'(bus_if.core_dout), 32'h1);
        tick();
        chk("B_t12_n1", 32'(bus_if.core_dout), 32'h1);
        tick();
        chk("B_t13_zero", 32'(bus_if.core_dout), 32'h0);
        chk("B_t13_idle", 32'(bus_if.idle), 32'h1);

        // Overflow with ready held low
        bus_if.core_dout_ready = 1'b0;
        write(1'b1, 1'b1, 16'h1234);
        tick();
        chk("C_full_after1", 32'(bus_if.full), 32'h0);
        tick();
        chk("C_full_after2", 32'(bus_if.full), 32'h1);
        chk("C_ovf_before3", 32'(bus_if.err_overflow), 32'h0);
        tick();
        bus_if.wr_en = 1'b0;
        chk("C_ovf_after3", 32'(bus_if.err_overflow), 32'h1);
        chk("C_full_after3", 32'(bus_if.full), 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("C_silent%0d", k), 32'(bus_if.core_dout), 32'h0);
        end
        chk("C_ovf_sticky", 32'(bus_if.err_overflow), 32'h1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("C_rst_full", 32'(bus_if.full), 32'h0);
        chk("C_rst_idle", 32'(bus_if.idle), 32'h1);
        chk("C_rst_ovf", 32'(bus_if.err_overflow), 32'h0);

        // Command with no flag set
        bus_if.core_dout_ready = 1'b1;
        write(1'b0, 1'b0, 16'hFFFF);
        tick();
        bus_if.wr_en = 1'b0;
        chk("D_err_cmd", 32'(bus_if.err_cmd), 32'h1);
        chk("D_idle", 32'(bus_if.idle), 32'h1);
        tick();
        tick();
        chk("D_dout", 32'(bus_if.core_dout), 32'h0);
        chk("D_idle_later", 32'(bus_if.idle), 32'h1);
        chk("D_err_sticky", 32'(bus_if.err_cmd), 32'h1);

        // Reset during index[11:8] of a long packet
        write(1'b1, 1'b0, 16'hBEEF);
        tick();
        bus_if.wr_en = 1'b0;
        tick();
        chk("E_n0", 32'(bus_if.core_dout), 32'h1);
        tick();
        chk("E_n1", 32'(bus_if.core_dout), 32'h2);
        tick();
        chk("E_n2", 32'(bus_if.core_dout), 32'hB);
        tick();
        chk("E_n3", 32'(bus_if.core_dout), 32'hE);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("E_abort_dout", 32'(bus_if.core_dout), 32'h0);
        chk("E_abort_idle", 32'(bus_if.idle), 32'h1);
        chk("E_abort_full", 32'(bus_if.full), 32'h0);
        chk("E_abort_err_cmd", 32'(bus_if.err_cmd), 32'h0);
        write(1'b1, 1'b1, 16'h0F96);
        tick();
        bus_if.wr_en = 1'b0;
        chk("E2_t1_dout", 32'(bus_if.core_dout), 32'h0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("E2_nib%0d", i), 32'(bus_if.core_dout), 32'(exp_e[i]));
        end
        chk("E2_end_idle", 32'(bus_if.idle), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
